// File: rtl/dot_product_stage_pkg.sv
// Shared FSM state type and accumulator width derivation for the dot-product stage.
package dot_product_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Headroom of log2(max_len) bits lets max_len full-scale products sum without overflow.
    function automatic int acc_width_f(input int data_width, input int max_len);
        return 2 * data_width + $clog2(max_len);
    endfunction

endpackage

// File: rtl/dot_product_stage_mac.sv
// Signed multiply-accumulate: full-precision product, sign-extended into the accumulator.
module mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 36
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         load_zero,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]    acc_d;
    logic signed [ACC_WIDTH-1:0]    acc_q;

    // load_zero wins over en so an abort or a new start never folds in a stale product.
    always_comb begin
        product = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
        acc_d   = acc_q;
        if (load_zero) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_WIDTH'(product);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/dot_product_stage.sv
// Streams len A/B operand pairs from two FIFOs, accumulates their dot product
// and pushes the result into an output FIFO.
module dot_product_stage
    import dot_product_stage_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  MAX_LEN    = 16,
    localparam int LEN_WIDTH  = $clog2(MAX_LEN + 1),
    localparam int ACC_WIDTH  = acc_width_f(DATA_WIDTH, MAX_LEN)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear,
    input  logic                         start,
    input  logic [LEN_WIDTH-1:0]         len,
    input  logic                         a_empty,
    input  logic signed [DATA_WIDTH-1:0] a_dout,
    output logic                         a_ren,
    input  logic                         b_empty,
    input  logic signed [DATA_WIDTH-1:0] b_dout,
    output logic                         b_ren,
    input  logic                         ps_full,
    output logic                         ps_wen,
    output logic signed [ACC_WIDTH-1:0]  ps_din,
    output logic                         busy,
    output logic                         done
);

    state_t                      state_q, state_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        done_q, done_d;
    logic                        fire;
    logic                        acc_zero;
    logic signed [ACC_WIDTH-1:0] acc;

    // Pops only when both heads are present so A/B pairs can never drift apart.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        fire     = 1'b0;
        acc_zero = 1'b0;
        ps_wen   = 1'b0;
        ps_din   = '0;
        if (clear) begin
            state_d  = IDLE;
            cnt_d    = '0;
            acc_zero = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (len != '0)) begin
                        len_d    = len;
                        cnt_d    = '0;
                        acc_zero = 1'b1;
                        state_d  = ACCUM;
                    end
                end
                ACCUM: begin
                    fire = !a_empty && !b_empty;
                    if (fire) begin
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                        if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    ps_wen = !ps_full;
                    if (!ps_full) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_q == WRITE) begin
            ps_din = acc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rstn     (rstn),
        .load_zero(acc_zero),
        .en       (fire),
        .a        (a_dout),
        .b        (b_dout),
        .acc      (acc)
    );

    assign a_ren = fire;
    assign b_ren = fire;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_dot_product_stage.sv
// Self-checking bench: bench-side FIFOs feed the stage, a pair-counting model
// predicts every pop/push per cycle, and directed cases pin literal results.
module tb_dot_product_stage;

    localparam int DW = 16;
    localparam int ML = 16;
    localparam int LW = $clog2(ML + 1);
    localparam int AW = 2 * DW + $clog2(ML);

    logic                 clk = 1'b0;
    logic                 rstn, clear, start;
    logic [LW-1:0]        len;
    logic                 a_empty, b_empty, a_ren, b_ren;
    logic signed [DW-1:0] a_dout, b_dout;
    logic                 ps_full, ps_wen, busy, done;
    logic signed [AW-1:0] ps_din;

    logic signed [DW-1:0] a_mem [32];
    logic signed [DW-1:0] b_mem [32];
    int                   a_rd, a_wr, b_rd, b_wr;
    logic                 a_block, b_block;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     op_active, done_due, pop_a, pop_b;
    int     exp_len, pops_seen, push_count, push_cyc, done_cyc, start_cyc;
    longint exp_sum, last_push;

    assign a_empty = a_block || (a_rd == a_wr);
    assign b_empty = b_block || (b_rd == b_wr);
    assign a_dout  = a_mem[a_rd[4:0]];
    assign b_dout  = b_mem[b_rd[4:0]];

    always #5 clk = ~clk;

    dot_product_stage #(.DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (clear),
        .start  (start),
        .len    (len),
        .a_empty(a_empty),
        .a_dout (a_dout),
        .a_ren  (a_ren),
        .b_empty(b_empty),
        .b_dout (b_dout),
        .b_ren  (b_ren),
        .ps_full(ps_full),
        .ps_wen (ps_wen),
        .ps_din (ps_din),
        .busy   (busy),
        .done   (done)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic longint memA(input int p);
        return longint'(a_mem[p[4:0]]);
    endfunction

    function automatic longint memB(input int p);
        return longint'(b_mem[p[4:0]]);
    endfunction

    // Model: an accepted op owes exactly len pair-pops, then one push of the dot
    // product of the next len queued pairs, then a done pulse.
    task automatic monitorCycle();
        bit exp_pop, exp_push, was_idle;
        pop_a = 1'b0;
        pop_b = 1'b0;
        if (!rstn) begin
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_a_ren", a_ren, 0);
            checkOutput("rst_b_ren", b_ren, 0);
            checkOutput("rst_ps_wen", ps_wen, 0);
            checkOutput("rst_ps_din", ps_din, 0);
            op_active = 1'b0;
            done_due  = 1'b0;
            return;
        end
        exp_pop  = op_active && (pops_seen < exp_len) && !a_empty && !b_empty && !clear;
        exp_push = op_active && (pops_seen == exp_len) && !ps_full && !clear;
        checkOutput("done", done, done_due);
        checkOutput("busy", busy, op_active);
        checkOutput("a_ren", a_ren, exp_pop);
        checkOutput("b_ren", b_ren, exp_pop);
        checkOutput("ps_wen", ps_wen, exp_push);
        if (op_active && (pops_seen == exp_len))
            checkOutput("ps_din", ps_din, exp_sum);
        if (done) done_cyc = cyc;
        pop_a    = a_ren && !a_empty;
        pop_b    = b_ren && !b_empty;
        was_idle = !op_active;
        done_due = 1'b0;
        if (clear) begin
            op_active = 1'b0;
        end else begin
            if (exp_pop) pops_seen++;
            if (ps_wen) begin
                push_count++;
                last_push = ps_din;
                push_cyc  = cyc;
                done_due  = 1'b1;
                op_active = 1'b0;
            end
            if (was_idle && start && (len != 0)) begin
                op_active = 1'b1;
                exp_len   = len;
                pops_seen = 0;
                exp_sum   = 0;
                for (int i = 0; i < exp_len; i++)
                    exp_sum += memA(a_rd + i) * memB(b_rd + i);
            end
        end
    endtask

    // Inputs change only just after a rising edge; the model samples on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        monitorCycle();
        @(posedge clk);
        #1;
        if (pop_a) a_rd++;
        if (pop_b) b_rd++;
    endtask

    task automatic loadPair(input int av, input int bv);
        a_mem[a_wr[4:0]] = DW'(av);
        b_mem[b_wr[4:0]] = DW'(bv);
        a_wr++;
        b_wr++;
    endtask

    task automatic applyStimulus(input int n);
        len   = LW'(n);
        start = 1'b1;
        tick();
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic waitPush(input int prev, input int budget);
        int k = 0;
        while (push_count == prev && k < budget) begin
            tick();
            k++;
        end
        checkOutput("push_seen", push_count, prev + 1);
    endtask

    initial begin
        int pc, rd0, s_prev;
        rstn = 1'b0; clear = 1'b0; start = 1'b0; len = '0; ps_full = 1'b0;
        a_block = 1'b0; b_block = 1'b0;
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
        op_active = 1'b0; done_due = 1'b0; push_count = 0; last_push = 0;
        push_cyc = 0; done_cyc = 0; start_cyc = 0; exp_len = 0; pops_seen = 0; exp_sum = 0;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        rstn = 1'b1;
        tick();

        $display("[TB] start with len=0 is ignored");
        applyStimulus(0);
        tick();
        checkOutput("len0_busy", busy, 0);

        $display("[TB] len=4: 1,2,3,4 . 5,6,7,8");
        for (int i = 0; i < 4; i++) loadPair(i + 1, i + 5);
        rd0 = a_rd;
        pc  = push_count;
        applyStimulus(4);
        waitPush(pc, 20);
        checkOutput("dot70", last_push, 70);
        checkOutput("wen_cycle", push_cyc - start_cyc + 1, 6);
        checkOutput("pops4", a_rd - rd0, 4);
        s_prev = start_cyc;

        $display("[TB] back-to-back len=1: -3 . 7");
        loadPair(-3, 7);
        pc = push_count;
        applyStimulus(1);
        checkOutput("done_cycle", done_cyc - s_prev + 1, 7);
        waitPush(pc, 20);
        checkOutput("dot_neg21", last_push, -21);
        tick();

        $display("[TB] len=16, all operands -32768");
        for (int i = 0; i < 16; i++) loadPair(-32768, -32768);
        pc = push_count;
        applyStimulus(16);
        waitPush(pc, 40);
        checkOutput("dot_fullscale", last_push, 64'sd17179869184);
        tick();

        $display("[TB] len=3 with B stalled 5 cycles");
        for (int i = 1; i <= 3; i++) loadPair(i, i);
        pc = push_count;
        applyStimulus(3);
        tick();
        b_block = 1'b1;
        rd0 = a_rd;
        repeat (5) tick();
        checkOutput("stall_pops", a_rd - rd0, 0);
        b_block = 1'b0;
        waitPush(pc, 20);
        checkOutput("dot14", last_push, 14);
        tick();

        $display("[TB] result FIFO full for 10 cycles");
        ps_full = 1'b1;
        loadPair(3, 5);
        loadPair(4, 6);
        pc = push_count;
        applyStimulus(2);
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("full_hold_din", ps_din, 39);
        end
        checkOutput("full_no_push", push_count, pc);
        ps_full = 1'b0;
        waitPush(pc, 5);
        checkOutput("dot39", last_push, 39);
        repeat (2) tick();
        checkOutput("single_push", push_count, pc + 1);

        $display("[TB] async reset mid-accumulate");
        for (int i = 1; i <= 4; i++) loadPair(i, i);
        applyStimulus(4);
        repeat (2) tick();
        checkOutput("pre_rst_busy", busy, 1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_a_ren", a_ren, 0);
        checkOutput("async_ps_wen", ps_wen, 0);
        checkOutput("async_ps_din", ps_din, 0);
        tick();
        rstn = 1'b1;
        a_rd = a_wr;
        b_rd = b_wr;
        loadPair(2, 4);
        loadPair(3, 5);
        pc = push_count;
        applyStimulus(2);
        waitPush(pc, 20);
        checkOutput("dot23", last_push, 23);
        tick();

        $display("[TB] clear while stuck in WRITE");
        ps_full = 1'b1;
        loadPair(5, 5);
        pc = push_count;
        applyStimulus(1);
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ps_full = 1'b0;
        tick();
        checkOutput("clr_busy", busy, 0);
        checkOutput("clr_done", done, 0);
        repeat (3) tick();
        checkOutput("clr_no_push", push_count, pc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
